// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file: default widths and the
// busy-bit encoding used instead of a sentinel "no tag" value.
package rename_regfile_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREG_DEF    = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int NCOMMIT_DEF = 1;

  // A register waits on a producer only when its busy bit is set; the stored
  // tag is meaningless while the bit is clear.
  localparam logic TAG_FREE = 1'b0;
  localparam logic TAG_BUSY = 1'b1;

endpackage

// File: rtl/rename_lookup.sv
// Per-operand source select: x0, same-cycle commit forward, pending tag,
// then the committed architectural value.
module rename_lookup
  import rename_regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NCOMMIT = NCOMMIT_DEF,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic [IDX_W-1:0]         idx,
  input  logic                     tbl_busy,
  input  logic [TAG_W-1:0]         tbl_tag,
  input  logic [XLEN-1:0]          tbl_val,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*IDX_W-1:0] cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_val,
  output logic                     busy,
  output logic [TAG_W-1:0]         tag,
  output logic [XLEN-1:0]          val
);

  logic            fwd_hit;
  logic [XLEN-1:0] fwd_val;

  // Find the youngest committing port that retires the current producer.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int k = 0; k < NCOMMIT; k++) begin
      if (cm_valid[k] &&
          cm_rd[k*IDX_W +: IDX_W] == idx &&
          cm_tag[k*TAG_W +: TAG_W] == tbl_tag) begin
        fwd_hit = 1'b1;
        fwd_val = cm_val[k*XLEN +: XLEN];
      end
    end
  end

  // Priority mux; tag is zero unless busy, value is zero when busy.
  always_comb begin
    busy = TAG_FREE;
    tag  = '0;
    val  = '0;
    if (idx == '0) begin
      val = '0;
    end else if (fwd_hit) begin
      val = fwd_val;
    end else if (tbl_busy == TAG_BUSY) begin
      busy = TAG_BUSY;
      tag  = tbl_tag;
    end else begin
      val = tbl_val;
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags. One dispatch
// lookup/rename per cycle, NCOMMIT in-order commits, flush drops all renames.
module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NCOMMIT = NCOMMIT_DEF,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     disp_valid,
  input  logic [IDX_W-1:0]         disp_rs1,
  input  logic [IDX_W-1:0]         disp_rs2,
  input  logic [IDX_W-1:0]         disp_rd,
  input  logic                     disp_rd_we,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [NCOMMIT-1:0]       cm_valid,
  input  logic [NCOMMIT*IDX_W-1:0] cm_rd,
  input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
  input  logic [NCOMMIT*XLEN-1:0]  cm_val,
  output logic                     op_valid,
  output logic                     op1_busy,
  output logic [TAG_W-1:0]         op1_tag,
  output logic [XLEN-1:0]          op1_val,
  output logic                     op2_busy,
  output logic [TAG_W-1:0]         op2_tag,
  output logic [XLEN-1:0]          op2_val
);

  logic [XLEN-1:0]  regs   [NREG];
  logic [TAG_W-1:0] tags   [NREG];
  logic [NREG-1:0]  busy;

  logic [XLEN-1:0]  reg_nx [NREG];
  logic [TAG_W-1:0] tag_nx [NREG];
  logic [NREG-1:0]  busy_nx;

  logic             accept;
  logic             l1_busy, l2_busy;
  logic [TAG_W-1:0] l1_tag, l2_tag;
  logic [XLEN-1:0]  l1_val, l2_val;

  assign accept = disp_valid & ~flush;

  rename_lookup #(
    .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT)
  ) u_lookup1 (
    .idx      (disp_rs1),
    .tbl_busy (busy[disp_rs1]),
    .tbl_tag  (tags[disp_rs1]),
    .tbl_val  (regs[disp_rs1]),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .busy     (l1_busy),
    .tag      (l1_tag),
    .val      (l1_val)
  );

  rename_lookup #(
    .XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NCOMMIT)
  ) u_lookup2 (
    .idx      (disp_rs2),
    .tbl_busy (busy[disp_rs2]),
    .tbl_tag  (tags[disp_rs2]),
    .tbl_val  (regs[disp_rs2]),
    .cm_valid (cm_valid),
    .cm_rd    (cm_rd),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .busy     (l2_busy),
    .tag      (l2_tag),
    .val      (l2_val)
  );

  // Next table state: commits first (youngest port last so it wins the value),
  // then flush or rename override busy/tag.
  always_comb begin
    reg_nx  = regs;
    tag_nx  = tags;
    busy_nx = busy;
    for (int k = 0; k < NCOMMIT; k++) begin
      if (cm_valid[k] && cm_rd[k*IDX_W +: IDX_W] != '0) begin
        reg_nx[cm_rd[k*IDX_W +: IDX_W]] = cm_val[k*XLEN +: XLEN];
        if (tags[cm_rd[k*IDX_W +: IDX_W]] == cm_tag[k*TAG_W +: TAG_W])
          busy_nx[cm_rd[k*IDX_W +: IDX_W]] = TAG_FREE;
      end
    end
    if (flush) begin
      busy_nx = '0;
    end else if (disp_valid && disp_rd_we && disp_rd != '0) begin
      busy_nx[disp_rd] = TAG_BUSY;
      tag_nx[disp_rd]  = disp_tag;
    end
  end

  // Table state register; everything freezes while rdy is low.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy) begin
      busy <= busy_nx;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= reg_nx[i];
        tags[i] <= tag_nx[i];
      end
    end
  end

  // Registered lookup results; operands refresh only on an accepted dispatch.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_valid <= 1'b0;
      op1_busy <= 1'b0;
      op1_tag  <= '0;
      op1_val  <= '0;
      op2_busy <= 1'b0;
      op2_tag  <= '0;
      op2_val  <= '0;
    end else if (rdy) begin
      op_valid <= accept;
      if (accept) begin
        op1_busy <= l1_busy;
        op1_tag  <= l1_tag;
        op1_val  <= l1_val;
        op2_busy <= l2_busy;
        op2_tag  <= l2_tag;
        op2_val  <= l2_val;
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile with two commit ports.
module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        clr, rdy, flush;
  logic        disp_valid, disp_rd_we;
  logic [4:0]  disp_rs1, disp_rs2, disp_rd;
  logic [3:0]  disp_tag;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_rd;
  logic [7:0]  cm_tag;
  logic [63:0] cm_val;
  logic        op_valid, op1_busy, op2_busy;
  logic [3:0]  op1_tag, op2_tag;
  logic [31:0] op1_val, op2_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rename_regfile #(.XLEN(32), .NREG(32), .TAG_W(4), .NCOMMIT(2)) dut (
    .clk(clk), .clr(clr), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rd(disp_rd), .disp_rd_we(disp_rd_we), .disp_tag(disp_tag),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .op_valid(op_valid), .op1_busy(op1_busy), .op1_tag(op1_tag), .op1_val(op1_val),
    .op2_busy(op2_busy), .op2_tag(op2_tag), .op2_val(op2_val)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; disp_rs1 = 0; disp_rs2 = 0; disp_rd = 0;
    disp_rd_we = 0; disp_tag = 0; cm_valid = 0; cm_rd = 0; cm_tag = 0; cm_val = 0;
  endtask

  task automatic dispatch(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic [3:0] t);
    disp_valid = 1; disp_rs1 = rs1; disp_rs2 = rs2; disp_rd = rd;
    disp_rd_we = we; disp_tag = t;
  endtask

  task automatic commit(input int p, input logic [4:0] rd, input logic [3:0] t,
                        input logic [31:0] v);
    cm_valid[p] = 1'b1;
    cm_rd[p*5 +: 5]   = rd;
    cm_tag[p*4 +: 4]  = t;
    cm_val[p*32 +: 32] = v;
  endtask

  // Advance one clock, sample 1 time unit after the edge, return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1; rdy = 1; idle();
    tick(); tick();
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op1_val", op1_val, 32'd0);
    chk("rst_op1_busy", {31'd0, op1_busy}, 32'd0);
    chk("rst_op2_val", op2_val, 32'd0);
    clr = 0;

    // Basic lookup of unwritten register and x0
    dispatch(5, 0, 0, 0, 0); tick();
    chk("basic_valid", {31'd0, op_valid}, 32'd1);
    chk("basic_op1_val", op1_val, 32'd0);
    chk("basic_op1_busy", {31'd0, op1_busy}, 32'd0);
    chk("basic_op2_val", op2_val, 32'd0);
    tick();
    chk("idle_valid", {31'd0, op_valid}, 32'd0);

    // Rename visible next cycle, then commit clears busy
    dispatch(0, 0, 3, 1, 7); tick();
    dispatch(3, 0, 0, 0, 0); tick();
    chk("ren_op1_busy", {31'd0, op1_busy}, 32'd1);
    chk("ren_op1_tag", {28'd0, op1_tag}, 32'd7);
    chk("ren_op1_val", op1_val, 32'd0);
    commit(0, 3, 7, 32'h1234); tick();
    dispatch(3, 0, 0, 0, 0); tick();
    chk("cm_op1_busy", {31'd0, op1_busy}, 32'd0);
    chk("cm_op1_val", op1_val, 32'h1234);
    chk("cm_op1_tag", {28'd0, op1_tag}, 32'd0);

    // Same-cycle commit forward into lookup
    dispatch(0, 0, 3, 1, 7); tick();
    dispatch(0, 3, 0, 0, 0); commit(0, 3, 7, 32'hABCD); tick();
    chk("fwd_op2_busy", {31'd0, op2_busy}, 32'd0);
    chk("fwd_op2_val", op2_val, 32'hABCD);
    dispatch(3, 0, 0, 0, 0); tick();
    chk("fwd_after_busy", {31'd0, op1_busy}, 32'd0);
    chk("fwd_after_val", op1_val, 32'hABCD);

    // Stale commit: value written, busy kept with newer tag
    dispatch(0, 0, 3, 1, 7); tick();
    dispatch(0, 0, 3, 1, 9); tick();
    dispatch(3, 0, 0, 0, 0); commit(0, 3, 7, 32'h55); tick();
    chk("stale_fwd_busy", {31'd0, op1_busy}, 32'd1);
    chk("stale_fwd_tag", {28'd0, op1_tag}, 32'd9);
    dispatch(3, 0, 0, 0, 0); tick();
    chk("stale_busy", {31'd0, op1_busy}, 32'd1);
    chk("stale_tag", {28'd0, op1_tag}, 32'd9);
    chk("stale_val", op1_val, 32'd0);

    // Two ports hit x6: port0 tag matches (forward + busy clear), port1 wins value
    dispatch(0, 0, 6, 1, 2); tick();
    dispatch(6, 0, 0, 0, 0); commit(0, 6, 2, 32'h111); commit(1, 6, 5, 32'h222); tick();
    chk("mp_fwd_val", op1_val, 32'h111);
    chk("mp_fwd_busy", {31'd0, op1_busy}, 32'd0);
    dispatch(6, 0, 0, 0, 0); tick();
    chk("mp_val", op1_val, 32'h222);
    chk("mp_busy", {31'd0, op1_busy}, 32'd0);

    // Flush with busy x1/x2/x3, simultaneous dispatch rd=4 and commit to x1
    dispatch(0, 0, 1, 1, 1); tick();
    dispatch(0, 0, 2, 1, 2); tick();
    flush = 1; dispatch(1, 2, 4, 1, 4); commit(0, 1, 1, 32'h99); tick();
    chk("flush_valid", {31'd0, op_valid}, 32'd0);
    dispatch(1, 2, 0, 0, 0); tick();
    chk("flush_x1_val", op1_val, 32'h99);
    chk("flush_x1_busy", {31'd0, op1_busy}, 32'd0);
    chk("flush_x2_busy", {31'd0, op2_busy}, 32'd0);
    chk("flush_x2_val", op2_val, 32'd0);
    dispatch(4, 3, 0, 0, 0); tick();
    chk("flush_x4_busy", {31'd0, op1_busy}, 32'd0);
    chk("flush_x4_val", op1_val, 32'd0);
    chk("flush_x3_busy", {31'd0, op2_busy}, 32'd0);
    chk("flush_x3_val", op2_val, 32'h55);

    // rdy low holds state and outputs
    dispatch(6, 1, 0, 0, 0); tick();
    chk("pre_hold_val1", op1_val, 32'h222);
    chk("pre_hold_val2", op2_val, 32'h99);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      dispatch(1, 1, 6, 1, 5); commit(0, 1, 0, 32'h77); tick();
      chk("hold_valid", {31'd0, op_valid}, 32'd1);
      chk("hold_val1", op1_val, 32'h222);
      chk("hold_val2", op2_val, 32'h99);
    end
    rdy = 1;
    tick();
    chk("post_hold_valid", {31'd0, op_valid}, 32'd0);
    dispatch(6, 1, 0, 0, 0); tick();
    chk("post_hold_busy1", {31'd0, op1_busy}, 32'd0);
    chk("post_hold_val1", op1_val, 32'h222);
    chk("post_hold_val2", op2_val, 32'h99);

    // Asynchronous clear mid-run
    dispatch(6, 1, 0, 0, 0); tick();
    #2; clr = 1; #1;
    chk("aclr_valid", {31'd0, op_valid}, 32'd0);
    chk("aclr_val1", op1_val, 32'd0);
    chk("aclr_val2", op2_val, 32'd0);
    @(negedge clk); clr = 0;
    dispatch(6, 0, 0, 0, 0); tick();
    chk("aclr_state_val", op1_val, 32'd0);
    chk("aclr_state_valid", {31'd0, op_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with a per-register rename-tag table (busy bit plus ROB tag) for the Tomasulo-style core.
- Each cycle it accepts one dispatch: it looks up two source operands and returns either a value or a producing ROB tag, and it renames the destination to a newly allocated ROB tag.
- It accepts up to NCOMMIT in-order ROB commits per cycle and forwards committing values into same-cycle lookups.
- A flush clears every pending rename while keeping the committed architectural values.

Parameters:
XLEN, 32, data width of registers and values
NREG, 32, number of architectural registers (power of 2)
TAG_W, 4, ROB tag width
NCOMMIT, 1, commit ports per cycle (1..4); a higher index is a younger instruction

Ports:
clk  in  1  clock
clr  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; when low, all state and outputs hold
flush  in  1  mispredict flush; clears all busy bits
disp_valid  in  1  dispatch request this cycle
disp_rs1  in  log2(NREG)  source 1 index
disp_rs2  in  log2(NREG)  source 2 index
disp_rd  in  log2(NREG)  destination index
disp_rd_we  in  1  dispatch writes rd
disp_tag  in  TAG_W  ROB tag allocated to this dispatch
cm_valid  in  NCOMMIT  per-port commit valid
cm_rd  in  NCOMMIT*log2(NREG)  per-port committed register
cm_tag  in  NCOMMIT*TAG_W  per-port committing ROB tag
cm_val  in  NCOMMIT*XLEN  per-port committed value
op_valid  out  1  lookup result valid (one-cycle pulse)
op1_busy  out  1  source 1 waits on a tag
op1_tag  out  TAG_W  producer tag; 0 when not busy
op1_val  out  XLEN  source 1 value; 0 when busy
op2_busy, op2_tag, op2_val  out  1/TAG_W/XLEN  same as op1_* for source 2

Behaviour:
- Reset (clr high, asynchronous): all registers 0, all busy 0, all tags 0, op_valid 0, all op* outputs 0. Deassertion is synchronous to clk. Reset mid-dispatch discards that dispatch.
- Register 0 always reads value 0, busy 0. Commits to x0 are ignored, and disp_rd=0 never renames.
- Latency: a lookup presented in cycle t appears on op* at edge t+1 with op_valid=1. op_valid=0 in any cycle without an accepted dispatch.
- Lookup source precedence, per operand, highest first:
  - x0 gives value 0.
  - A same-cycle commit matching both register and the table's current tag gives that commit's value, busy 0. With several matches, the highest port wins.
  - Table busy gives busy 1 with the table tag.
  - Otherwise the table value.
- A lookup never sees its own dispatch's rename: rs1==rd returns the old mapping.
- A rename from cycle t-1 is visible to the lookup in cycle t, because the state is written at edge t.
- Commit rules, for each valid port k and rd≠0:
  - REG[rd] ← cm_val[k], always.
  - busy[rd] clears only if tag[rd]==cm_tag[k].
  - If several ports write the same rd, the highest k wins the value. The busy clear applies if any port's tag matches.
- Rename: if disp_valid & disp_rd_we & rd≠0, then busy[rd] ← 1 and tag[rd] ← disp_tag. When a rename and a commit hit the same register in the same cycle, the rename wins busy/tag and the commit still writes the value.
- Flush (synchronous, while rdy):
  - All busy bits clear.
  - The dispatch that cycle is ignored and op_valid is 0 next cycle.
  - Commits that cycle are still applied.
- rdy low: no updates; op* and op_valid hold their values; inputs are ignored.
- Implementation uses no latches and no blocking assignments to state; all state updates happen on the posedge only.

Decomposition:
- Shared package constants: XLEN, TAG_W, NREG defaults, and the tag-empty encoding (busy bit rather than a sentinel value).
- One natural sub-module, rename_lookup: combinational per-operand precedence mux (x0, commit forward, busy, value), instantiated twice.

Test Plan:
- Reset, then dispatch rs1=5, rs2=0 → next cycle op_valid=1, op1_val=0, op1_busy=0, op2_val=0.
- Dispatch rd=3 with tag 7, then next cycle dispatch rs1=3 → op1_busy=1, op1_tag=7. Then commit (rd=3, tag=7, val=0x1234) → a later lookup of x3 gives busy 0, val 0x1234.
- Same-cycle forward: x3 is busy with tag 7, and commit (3, 7, 0xABCD) occurs in the same cycle as a dispatch with rs2=3 → op2_busy=0, op2_val=0xABCD.
- Stale commit: x3 is renamed to tag 7 then to tag 9; commit (3, 7, 0x55) → REG[3]=0x55, x3 still busy with tag 9.
- Flush with x1 and x2 busy plus a simultaneous dispatch rd=4 and commit (1, tag, 0x99) → all busy bits 0, x4 not renamed, REG[1]=0x99, op_valid=0.
- rdy low for 3 cycles during a dispatch/commit → no state change and outputs held. Asserting clr mid-run → all outputs 0 immediately, without waiting for a clock edge.
